control_sequencer: RTL and testbench

//  Microcode step sequencer and decoder for the 8-bit CPU. Steps through fetch and execute

---
 rtl/control_sequencer.sv | 226 ++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// ---------------------------------------------------------------------------
// control_sequencer
//
// Microcode step sequencer and decoder for the 8-bit CPU.
// It walks through the fetch micro-steps (T0, T1) and then the execute steps
// of the current instruction (T2..T4). It also drives every datapath control
// strobe.
//
// The state and step registers change on the rising clock edge. This keeps
// the strobes stable before the datapath registers latch on the falling edge.
//
// Ports
//   clk                         system clock
//   reset                       async, active-high; forces INIT
//   run                         1 = execute; 0 = freeze step, all strobes 0
//   opcode                      current IR opcode (IR upper nibble)
//   flag_carry / flag_zero      latched ALU flags, used by JC / JZ
//   pc_count / pc_jump          program counter increment / load from bus
//   pc_out_en                   program counter drives the bus
//   pc_reset                    program counter synchronous clear
//   mar_load                    MAR load
//   ram_out_en / ram_load       RAM read onto the bus / RAM write from the bus
//   ir_load / ir_out_en         IR load / IR operand nibble drives the bus
//   a_load / a_out_en / b_load  accumulator and B register control
//   alu_out_en / alu_sub        ALU result drives the bus / subtract select
//   flags_load / out_load       flags register load / output register load
//   halted                      1 once HLT has executed
//   step                        current micro-step, for debug
// ---------------------------------------------------------------------------
module control_sequencer #(
  parameter int OPCODE_W = 4,
  parameter int STEP_W   = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                flag_carry,
  input  logic                flag_zero,
  output logic                pc_count,
  output logic                pc_jump,
  output logic                pc_out_en,
  output logic                pc_reset,
  output logic                mar_load,
  output logic                ram_out_en,
  output logic                ram_load,
  output logic                ir_load,
  output logic                ir_out_en,
  output logic                a_load,
  output logic                a_out_en,
  output logic                b_load,
  output logic                alu_out_en,
  output logic                alu_sub,
  output logic                flags_load,
  output logic                out_load,
  output logic                halted,
  output logic [STEP_W-1:0]   step
);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_LDA = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_SUB = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_STA = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_LDI = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_JMP = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OP_JC  = OPCODE_W'(7);
  localparam logic [OPCODE_W-1:0] OP_JZ  = OPCODE_W'(8);
  localparam logic [OPCODE_W-1:0] OP_OUT = OPCODE_W'(14);
  localparam logic [OPCODE_W-1:0] OP_HLT = OPCODE_W'(15);

  localparam logic [STEP_W-1:0] T0 = STEP_W'(0);
  localparam logic [STEP_W-1:0] T1 = STEP_W'(1);
  localparam logic [STEP_W-1:0] T2 = STEP_W'(2);
  localparam logic [STEP_W-1:0] T3 = STEP_W'(3);
  localparam logic [STEP_W-1:0] T4 = STEP_W'(4);

  state_t            state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              uses_mem;
  logic              uses_alu;
  logic              last_step;

  // State register. Reset abandons any partial instruction immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_INIT;
      step_q  <= T0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  // The instruction length comes from the opcode.
  // Memory-operand instructions run to T3. ADD and SUB also need T4.
  // Steps at or beyond T4 always wrap back to T0, so the step value cannot
  // run away.
  always_comb begin
    uses_mem  = (opcode == OP_LDA) || (opcode == OP_ADD) ||
                (opcode == OP_SUB) || (opcode == OP_STA);
    uses_alu  = (opcode == OP_ADD) || (opcode == OP_SUB);
    last_step = (step_q >= T4) ||
                ((step_q == T2) && !uses_mem) ||
                ((step_q == T3) && !uses_alu);
  end

  // Next-state logic. With run low, both the state and the step are held.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    if (run) begin
      unique case (state_q)
        ST_INIT: begin
          state_d = ST_RUN;
          step_d  = T0;
        end
        ST_RUN: begin
          if ((step_q == T2) && (opcode == OP_HLT)) begin
            state_d = ST_HALT;
            step_d  = T0;
          end else if (last_step) begin
            step_d  = T0;
          end else begin
            step_d  = step_q + STEP_W'(1);
          end
        end
        ST_HALT: begin
          step_d = T0;
        end
        default: begin
          state_d = ST_INIT;
          step_d  = T0;
        end
      endcase
    end
  end

  // Output decode. Each step lets at most one bus driver onto the bus.
  // The run signal gates every strobe, including pc_reset in INIT.
  // The halted status is not gated by run.
  always_comb begin
    pc_count   = 1'b0;
    pc_jump    = 1'b0;
    pc_out_en  = 1'b0;
    pc_reset   = 1'b0;
    mar_load   = 1'b0;
    ram_out_en = 1'b0;
    ram_load   = 1'b0;
    ir_load    = 1'b0;
    ir_out_en  = 1'b0;
    a_load     = 1'b0;
    a_out_en   = 1'b0;
    b_load     = 1'b0;
    alu_out_en = 1'b0;
    alu_sub    = 1'b0;
    flags_load = 1'b0;
    out_load   = 1'b0;
    halted     = (state_q == ST_HALT);
    step       = step_q;
    if (run && (state_q == ST_INIT)) begin
      pc_reset = 1'b1;
    end else if (run && (state_q == ST_RUN)) begin
      unique case (step_q)
        T0: begin
          pc_out_en = 1'b1;
          mar_load  = 1'b1;
        end
        T1: begin
          ram_out_en = 1'b1;
          ir_load    = 1'b1;
          pc_count   = 1'b1;
        end
        T2: begin
          if (uses_mem) begin
            ir_out_en = 1'b1;
            mar_load  = 1'b1;
          end else if (opcode == OP_LDI) begin
            ir_out_en = 1'b1;
            a_load    = 1'b1;
          end else if (opcode == OP_JMP) begin
            ir_out_en = 1'b1;
            pc_jump   = 1'b1;
          end else if (opcode == OP_JC) begin
            ir_out_en = 1'b1;
            pc_jump   = flag_carry;
          end else if (opcode == OP_JZ) begin
            ir_out_en = 1'b1;
            pc_jump   = flag_zero;
          end else if (opcode == OP_OUT) begin
            a_out_en = 1'b1;
            out_load = 1'b1;
          end
        end
        T3: begin
          if (opcode == OP_LDA) begin
            ram_out_en = 1'b1;
            a_load     = 1'b1;
          end else if (opcode == OP_STA) begin
            a_out_en = 1'b1;
            ram_load = 1'b1;
          end else if (uses_alu) begin
            ram_out_en = 1'b1;
            b_load     = 1'b1;
          end
        end
        T4: begin
          if (uses_alu) begin
            alu_out_en = 1'b1;
            a_load     = 1'b1;
            flags_load = 1'b1;
            alu_sub    = (opcode == OP_SUB);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// ---------------------------------------------------------------------------
// tb_control_sequencer
//
// Self-checking bench for control_sequencer.
// The reference model tracks the sequencer as (phase, step number). It
// advances the step using each instruction's length in steps. The expected
// strobes come from a microcode table keyed on opcode and step.
// ---------------------------------------------------------------------------
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic [3:0] opcode;
  logic       flag_carry;
  logic       flag_zero;
  logic       pc_count, pc_jump, pc_out_en, pc_reset, mar_load;
  logic       ram_out_en, ram_load, ir_load, ir_out_en;
  logic       a_load, a_out_en, b_load, alu_out_en, alu_sub;
  logic       flags_load, out_load, halted;
  logic [2:0] step;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Model phase: 0 = INIT, 1 = running, 2 = halted.
  int m_phase = 0;
  int m_step  = 0;

  // Bit positions of the strobes within a packed 16-bit vector.
  localparam int B_PC_COUNT = 15, B_PC_JUMP = 14, B_PC_OUT = 13, B_PC_RESET = 12;
  localparam int B_MAR = 11, B_RAM_OUT = 10, B_RAM_LOAD = 9, B_IR_LOAD = 8;
  localparam int B_IR_OUT = 7, B_A_LOAD = 6, B_A_OUT = 5, B_B_LOAD = 4;
  localparam int B_ALU_OUT = 3, B_ALU_SUB = 2, B_FLAGS = 1, B_OUT_LOAD = 0;

  control_sequencer #(.OPCODE_W(4), .STEP_W(3)) dut (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode),
    .flag_carry(flag_carry), .flag_zero(flag_zero),
    .pc_count(pc_count), .pc_jump(pc_jump), .pc_out_en(pc_out_en),
    .pc_reset(pc_reset), .mar_load(mar_load), .ram_out_en(ram_out_en),
    .ram_load(ram_load), .ir_load(ir_load), .ir_out_en(ir_out_en),
    .a_load(a_load), .a_out_en(a_out_en), .b_load(b_load),
    .alu_out_en(alu_out_en), .alu_sub(alu_sub), .flags_load(flags_load),
    .out_load(out_load), .halted(halted), .step(step)
  );

  always #5 clk = ~clk;

  // Number of micro-steps (fetch included) each instruction takes.
  function automatic int instr_len(input int op);
    case (op)
      1, 4:    return 4;
      2, 3:    return 5;
      default: return 3;
    endcase
  endfunction

  function automatic logic [15:0] dut_strobes();
    return {pc_count, pc_jump, pc_out_en, pc_reset, mar_load, ram_out_en,
            ram_load, ir_load, ir_out_en, a_load, a_out_en, b_load,
            alu_out_en, alu_sub, flags_load, out_load};
  endfunction

  // Microcode table: the expected strobes for the model's current position.
  function automatic logic [15:0] exp_strobes();
    logic [15:0] v;
    int op;
    v  = '0;
    op = int'(opcode);
    if (run && m_phase == 0) v[B_PC_RESET] = 1'b1;
    if (run && m_phase == 1) begin
      if (m_step == 0) begin
        v[B_PC_OUT] = 1'b1; v[B_MAR] = 1'b1;
      end
      if (m_step == 1) begin
        v[B_RAM_OUT] = 1'b1; v[B_IR_LOAD] = 1'b1; v[B_PC_COUNT] = 1'b1;
      end
      if (m_step == 2) begin
        if (op >= 1 && op <= 4) begin v[B_IR_OUT] = 1'b1; v[B_MAR] = 1'b1; end
        if (op == 5) begin v[B_IR_OUT] = 1'b1; v[B_A_LOAD] = 1'b1; end
        if (op == 6) begin v[B_IR_OUT] = 1'b1; v[B_PC_JUMP] = 1'b1; end
        if (op == 7) begin v[B_IR_OUT] = 1'b1; v[B_PC_JUMP] = flag_carry; end
        if (op == 8) begin v[B_IR_OUT] = 1'b1; v[B_PC_JUMP] = flag_zero; end
        if (op == 14) begin v[B_A_OUT] = 1'b1; v[B_OUT_LOAD] = 1'b1; end
      end
      if (m_step == 3) begin
        if (op == 1) begin v[B_RAM_OUT] = 1'b1; v[B_A_LOAD] = 1'b1; end
        if (op == 4) begin v[B_A_OUT] = 1'b1; v[B_RAM_LOAD] = 1'b1; end
        if (op == 2 || op == 3) begin v[B_RAM_OUT] = 1'b1; v[B_B_LOAD] = 1'b1; end
      end
      if (m_step == 4 && (op == 2 || op == 3)) begin
        v[B_ALU_OUT] = 1'b1; v[B_A_LOAD] = 1'b1; v[B_FLAGS] = 1'b1;
        v[B_ALU_SUB] = (op == 3);
      end
    end
    return v;
  endfunction

  // Advance one rising edge and move the model with it.
  // The task then waits #1 so that the DUT outputs are settled for sampling.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      m_phase = 0; m_step = 0;
    end else if (run) begin
      if (m_phase == 0) begin
        m_phase = 1; m_step = 0;
      end else if (m_phase == 1) begin
        if (m_step == 2 && int'(opcode) == 15) begin
          m_phase = 2; m_step = 0;
        end else if (m_step + 1 >= instr_len(int'(opcode))) begin
          m_step = 0;
        end else begin
          m_step = m_step + 1;
        end
      end
    end
    #1;
  endtask

  // Reset the DUT, release reset, and leave it at T0 with the given opcode.
  task automatic start_instr(input logic [3:0] op);
    reset = 1'b1; m_phase = 0; m_step = 0;
    run = 1'b1; opcode = op;
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    logic [15:0] act;
    reset = 1'b1; run = 1'b0; opcode = 4'd0; flag_carry = 1'b0; flag_zero = 1'b0;
    m_phase = 0; m_step = 0;
    repeat (2) @(posedge clk);
    #1 run = 1'b1;
    #1 act = dut_strobes();
    n_compared++;
    if (act !== 16'h1000 || step !== 3'd0 || halted !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_state strobes=%h step=%0d halted=%b required 1000/0/0", act, step, halted);
    end
    @(negedge clk) reset = 1'b0;
    tick();
    act = dut_strobes();
    n_compared++;
    if (act !== 16'h2800 || step !== 3'd0) begin
      n_mismatched++;
      $display("[TB] FAIL fetch_t0 strobes=%h step=%0d required 2800/0", act, step);
    end
    tick();
    act = dut_strobes();
    n_compared++;
    if (act !== 16'h8500 || step !== 3'd1) begin
      n_mismatched++;
      $display("[TB] FAIL fetch_t1 strobes=%h step=%0d required 8500/1", act, step);
    end
  endtask

  task automatic test_add();
    int exp_steps[6] = '{0, 1, 2, 3, 4, 0};
    logic [15:0] act;
    start_instr(4'd2);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      act = dut_strobes();
      n_compared++;
      if (int'(step) !== exp_steps[i] || act !== exp_strobes()) begin
        n_mismatched++;
        $display("[TB] FAIL add_seq[%0d] step=%0d strobes=%h required %0d/%h", i, step, act, exp_steps[i], exp_strobes());
      end
      if (i == 4) begin
        n_compared++;
        if (act !== 16'h004A) begin
          n_mismatched++;
          $display("[TB] FAIL add_t4 strobes=%h required 004a", act);
        end
      end
    end
  endtask

  task automatic test_jc();
    logic [15:0] act;
    logic [15:0] want;
    for (int c = 0; c < 2; c++) begin
      start_instr(4'd7);
      flag_carry = (c == 1);
      tick(); tick();
      act  = dut_strobes();
      want = (c == 1) ? 16'h4080 : 16'h0080;
      n_compared++;
      if (act !== want || step !== 3'd2) begin
        n_mismatched++;
        $display("[TB] FAIL jc_t2 carry=%0d strobes=%h step=%0d required %h/2", c, act, step, want);
      end
      tick();
      n_compared++;
      if (step !== 3'd0) begin
        n_mismatched++;
        $display("[TB] FAIL jc_next carry=%0d step=%0d required 0", c, step);
      end
    end
    flag_carry = 1'b0;
  endtask

  task automatic test_halt();
    logic [15:0] act;
    start_instr(4'd15);
    tick(); tick();
    act = dut_strobes();
    n_compared++;
    if (act !== 16'h0000 || halted !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL hlt_t2 strobes=%h halted=%b required 0000/0", act, halted);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      act = dut_strobes();
      n_compared++;
      if (act !== 16'h0000 || halted !== 1'b1 || step !== 3'd0 || m_phase != 2) begin
        n_mismatched++;
        $display("[TB] FAIL halt_hold[%0d] strobes=%h halted=%b step=%0d required 0000/1/0", i, act, halted, step);
      end
    end
    reset = 1'b1; m_phase = 0; m_step = 0;
    #1 act = dut_strobes();
    n_compared++;
    if (act !== 16'h1000 || halted !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL halt_reset strobes=%h halted=%b required 1000/0", act, halted);
    end
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic test_freeze();
    logic [15:0] act;
    start_instr(4'd1);
    tick(); tick(); tick();
    run = 1'b0;
    #1 act = dut_strobes();
    n_compared++;
    if (act !== 16'h0000 || step !== 3'd3) begin
      n_mismatched++;
      $display("[TB] FAIL freeze_enter strobes=%h step=%0d required 0000/3", act, step);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      act = dut_strobes();
      n_compared++;
      if (act !== 16'h0000 || step !== 3'd3) begin
        n_mismatched++;
        $display("[TB] FAIL freeze_hold[%0d] strobes=%h step=%0d required 0000/3", i, act, step);
      end
    end
    run = 1'b1;
    #1 act = dut_strobes();
    n_compared++;
    if (act !== 16'h0440 || step !== 3'd3) begin
      n_mismatched++;
      $display("[TB] FAIL freeze_resume strobes=%h step=%0d required 0440/3", act, step);
    end
    tick();
    act = dut_strobes();
    n_compared++;
    if (act !== 16'h2800 || step !== 3'd0) begin
      n_mismatched++;
      $display("[TB] FAIL freeze_next strobes=%h step=%0d required 2800/0", act, step);
    end
  endtask

  task automatic test_async_reset();
    logic [15:0] act;
    start_instr(4'd4);
    tick(); tick();
    act = dut_strobes();
    n_compared++;
    if (act !== 16'h0880 || step !== 3'd2) begin
      n_mismatched++;
      $display("[TB] FAIL sta_t2 strobes=%h step=%0d required 0880/2", act, step);
    end
    #2 reset = 1'b1; m_phase = 0; m_step = 0;
    #1 act = dut_strobes();
    n_compared++;
    if (act !== 16'h1000 || step !== 3'd0 || halted !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL async_reset strobes=%h step=%0d required 1000/0", act, step);
    end
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic test_random();
    logic [15:0] act;
    start_instr(4'($urandom_range(0, 15)));
    for (int i = 0; i < 600; i++) begin
      if (m_phase == 2 && $urandom_range(0, 3) == 0) begin
        start_instr(4'($urandom_range(0, 15)));
      end else begin
        tick();
      end
      if (m_phase == 1 && m_step == 0) opcode = 4'($urandom_range(0, 15));
      flag_carry = 1'($urandom_range(0, 1));
      flag_zero  = 1'($urandom_range(0, 1));
      run        = ($urandom_range(0, 7) != 0);
      #1 act = dut_strobes();
      n_compared++;
      if (act !== exp_strobes() || int'(step) !== m_step || halted !== (m_phase == 2)) begin
        n_mismatched++;
        $display("[TB] FAIL random[%0d] op=%0d strobes=%h step=%0d halted=%b required %h/%0d/%0d",
                 i, opcode, act, step, halted, exp_strobes(), m_step, (m_phase == 2));
      end
      n_compared++;
      if ($countones({pc_out_en, ram_out_en, ir_out_en, a_out_en, alu_out_en}) > 1 ||
          (pc_count && pc_jump)) begin
        n_mismatched++;
        $display("[TB] FAIL bus_invariant[%0d] strobes=%h required one bus driver, no count+jump", i, act);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_jc();
    test_halt();
    test_freeze();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
